// File: rtl/i2c_cmd_pkg.sv
// Shared command codes, transaction modes and sequencer states for the I2C master command port.
package i2c_cmd_pkg;

  localparam int unsigned CMD_W  = 3;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 8;

  typedef enum logic [CMD_W-1:0] {
    MAIN_CMD_IDLE = 3'd0,
    COMPLETE_WR   = 3'd1,
    WR_WNO_STOP   = 3'd2,
    COMPLETE_RD   = 3'd3,
    RD_WNO_STOP   = 3'd4,
    SET_IDLE      = 3'd5
  } cmd_e;

  localparam int unsigned MODE_WR    = 0;
  localparam int unsigned MODE_RD    = 1;
  localparam int unsigned MODE_WR_RD = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_CMD,
    ST_WR_DATA,
    ST_RD_CMD,
    ST_RD_DATA,
    ST_FSH
  } state_e;

endpackage

// File: rtl/common_interface.sv
// Command/data port between a transaction driver and the I2C master core.
interface common_interface;
  import i2c_cmd_pkg::*;

  logic              clock;
  logic              rst_n;
  cmd_e              cmd;
  logic              cmd_vld;
  logic              cmd_ready;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  burst_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_vld;
  logic              wr_ready;
  logic              wr_last;
  logic [DATA_W-1:0] rd_data;
  logic              rd_vld;
  logic              rd_ready;
  logic              rd_last;

  modport master (
    input  clock, rst_n, cmd_ready, wr_ready, rd_data, rd_vld, rd_last,
    output cmd, cmd_vld, addr, burst_len, wr_data, wr_vld, wr_last, rd_ready
  );

  modport slave (
    input  clock, rst_n, cmd, cmd_vld, addr, burst_len, wr_data, wr_vld, wr_last, rd_ready,
    output cmd_ready, wr_ready, rd_data, rd_vld, rd_last
  );
endinterface

// File: rtl/i2c_burst_access.sv
// Burst transaction sequencer: write, read, or write-then-read (repeated start) on the
// master command port, with read beat count, read checksum and sticky protocol error.
module i2c_burst_access
  import i2c_cmd_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DEV_ADDR   = 7'h50,
  parameter int unsigned       MODE       = MODE_WR_RD,
  parameter int unsigned       BURST_LEN  = 4,
  parameter int unsigned       PTR_LEN    = 1,
  parameter logic [DATA_W-1:0] WDATA_BASE = 8'h81
) (
  input  logic               enable,
  common_interface.master    cinf,
  output logic               busy,
  output logic               done,
  output logic [LEN_W-1:0]   rd_cnt,
  output logic [DATA_W-1:0]  rd_xor,
  output logic               err
);

  localparam logic [LEN_W-1:0] RD_LEN  = LEN_W'(BURST_LEN);
  localparam logic [LEN_W-1:0] WR_LEN  = LEN_W'((MODE == MODE_WR) ? BURST_LEN : PTR_LEN);
  localparam cmd_e             WR_CODE = (MODE == MODE_WR) ? COMPLETE_WR : WR_WNO_STOP;

  state_e             cstate, nstate;
  logic [LEN_W-1:0]   beat, beat_n;
  logic [LEN_W-1:0]   rd_cnt_n, burst_len_n;
  logic [DATA_W-1:0]  rd_xor_n, wr_data_n;
  logic               cmd_vld_n, wr_vld_n, wr_last_n, rd_ready_n;
  logic               busy_n, done_n, err_n;
  logic               cmd_hs, wr_hs, rd_hs, rd_full;
  cmd_e               cmd_n;

  assign cinf.addr = DEV_ADDR;

  // Next state plus the next value of every registered output.
  always_comb begin
    nstate   = cstate;
    beat_n   = beat;
    rd_cnt_n = rd_cnt;
    rd_xor_n = rd_xor;
    err_n    = err;
    cmd_hs   = cinf.cmd_vld & cinf.cmd_ready;
    wr_hs    = cinf.wr_vld & cinf.wr_ready;
    rd_hs    = cinf.rd_ready & cinf.rd_vld;
    rd_full  = (rd_cnt + LEN_W'(1)) == RD_LEN;

    case (cstate)
      ST_IDLE: begin
        if (enable) begin
          nstate   = (MODE == MODE_RD) ? ST_RD_CMD : ST_WR_CMD;
          rd_cnt_n = '0;
          rd_xor_n = '0;
        end
      end
      ST_WR_CMD:  if (cmd_hs) nstate = ST_WR_DATA;
      ST_WR_DATA: begin
        if (wr_hs) begin
          beat_n = beat + LEN_W'(1);
          if (cinf.wr_last) nstate = (MODE == MODE_WR) ? ST_FSH : ST_RD_CMD;
        end
      end
      ST_RD_CMD:  if (cmd_hs) nstate = ST_RD_DATA;
      ST_RD_DATA: begin
        if (rd_hs) begin
          rd_cnt_n = rd_cnt + LEN_W'(1);
          rd_xor_n = rd_xor ^ cinf.rd_data;
          // Exit on whichever of rd_last / full count comes first; disagreement is an error.
          if (cinf.rd_last || rd_full) begin
            nstate = ST_FSH;
            if (cinf.rd_last != rd_full) err_n = 1'b1;
          end
        end
      end
      ST_FSH:  nstate = ST_IDLE;
      default: nstate = ST_IDLE;
    endcase

    if (nstate != ST_WR_DATA) beat_n = '0;

    // Valids rise one cycle after the phase is entered and drop right after the handshake.
    cmd_vld_n   = (nstate == cstate) && ((cstate == ST_WR_CMD) || (cstate == ST_RD_CMD));
    wr_vld_n    = (cstate == ST_WR_DATA) && (nstate == ST_WR_DATA);
    wr_last_n   = wr_vld_n && (beat_n == (WR_LEN - LEN_W'(1)));
    wr_data_n   = WDATA_BASE + beat_n;
    rd_ready_n  = (nstate == ST_RD_DATA);
    busy_n      = (nstate != ST_IDLE);
    done_n      = (nstate == ST_FSH);
    burst_len_n = (nstate == ST_WR_CMD) ? WR_LEN : RD_LEN;

    case (nstate)
      ST_WR_CMD: cmd_n = WR_CODE;
      ST_RD_CMD: cmd_n = COMPLETE_RD;
      default:   cmd_n = MAIN_CMD_IDLE;
    endcase
  end

  always_ff @(posedge cinf.clock) begin
    if (!cinf.rst_n) begin
      cstate         <= ST_IDLE;
      beat           <= '0;
      cinf.cmd       <= MAIN_CMD_IDLE;
      cinf.cmd_vld   <= 1'b0;
      cinf.burst_len <= '0;
      cinf.wr_data   <= '0;
      cinf.wr_vld    <= 1'b0;
      cinf.wr_last   <= 1'b0;
      cinf.rd_ready  <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      rd_cnt         <= '0;
      rd_xor         <= '0;
    end else begin
      cstate         <= nstate;
      beat           <= beat_n;
      cinf.cmd       <= cmd_n;
      cinf.cmd_vld   <= cmd_vld_n;
      cinf.burst_len <= burst_len_n;
      cinf.wr_data   <= wr_data_n;
      cinf.wr_vld    <= wr_vld_n;
      cinf.wr_last   <= wr_last_n;
      cinf.rd_ready  <= rd_ready_n;
      busy           <= busy_n;
      done           <= done_n;
      err            <= err_n;
      rd_cnt         <= rd_cnt_n;
      rd_xor         <= rd_xor_n;
    end
  end

endmodule

// File: tb/tb_i2c_burst_access.sv
// Bench for i2c_burst_access: five configurations share one randomised slave model.
module tb_i2c_burst_access;
  import i2c_cmd_pkg::*;

  localparam int unsigned N_DUT = 5;
  localparam int unsigned CFG_MODE [N_DUT] = '{MODE_WR, MODE_RD, MODE_RD, MODE_WR_RD, MODE_RD};
  localparam int unsigned CFG_BL   [N_DUT] = '{4, 1, 4, 3, 2};
  localparam int unsigned D_WR = 0, D_RD1 = 1, D_RD4 = 2, D_WRRD = 3, D_RD2 = 4;
  localparam int MAX_CYC = 300;

  logic             clk;
  logic             rst_n;
  logic [N_DUT-1:0] enable;
  logic             cmd_ready, wr_ready, rd_vld, rd_last;
  logic [7:0]       rd_data;

  cmd_e       o_cmd     [N_DUT];
  logic [6:0] o_addr    [N_DUT];
  logic [7:0] o_blen    [N_DUT];
  logic [7:0] o_wdata   [N_DUT];
  logic [7:0] o_rcnt    [N_DUT];
  logic [7:0] o_rxor    [N_DUT];
  logic       o_cmd_vld [N_DUT];
  logic       o_wr_vld  [N_DUT];
  logic       o_wr_last [N_DUT];
  logic       o_rd_ready[N_DUT];
  logic       o_busy    [N_DUT];
  logic       o_done    [N_DUT];
  logic       o_err     [N_DUT];

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    common_interface cinf ();
    assign cinf.clock     = clk;
    assign cinf.rst_n     = rst_n;
    assign cinf.cmd_ready = cmd_ready;
    assign cinf.wr_ready  = wr_ready;
    assign cinf.rd_data   = rd_data;
    assign cinf.rd_vld    = rd_vld;
    assign cinf.rd_last   = rd_last;
    assign o_cmd[g]       = cinf.cmd;
    assign o_addr[g]      = cinf.addr;
    assign o_blen[g]      = cinf.burst_len;
    assign o_wdata[g]     = cinf.wr_data;
    assign o_cmd_vld[g]   = cinf.cmd_vld;
    assign o_wr_vld[g]    = cinf.wr_vld;
    assign o_wr_last[g]   = cinf.wr_last;
    assign o_rd_ready[g]  = cinf.rd_ready;

    i2c_burst_access #(
      .DEV_ADDR  (7'h50),
      .MODE      (CFG_MODE[g]),
      .BURST_LEN (CFG_BL[g]),
      .PTR_LEN   (1),
      .WDATA_BASE(8'h81)
    ) u_dut (
      .enable(enable[g]),
      .cinf  (cinf),
      .busy  (o_busy[g]),
      .done  (o_done[g]),
      .rd_cnt(o_rcnt[g]),
      .rd_xor(o_rxor[g]),
      .err   (o_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Slave behaviour knobs and scoreboard filled by run_txn.
  int         wr_mode;
  int         last_at;
  logic [7:0] rd_src[$];
  cmd_e       cmd_q[$];
  logic [7:0] len_q[$];
  logic [7:0] wr_q[$];
  logic       wl_q[$];
  logic [7:0] cap_cnt[$];
  logic [7:0] cap_xor[$];
  logic       cap_err[$];
  int         mdl_n[2];
  logic [7:0] mdl_x[2];
  int         done_cnt, lat, stab_err;
  logic       post_done, post_busy;
  bit         timed_out;

  // Starts a transaction on DUT sel and plays the slave until n_done done pulses are seen.
  task automatic run_txn(input int sel, input bit hold, input int n_done);
    int rbeat;
    bit stall_w, stall_c;
    logic [7:0] pw_data;
    logic pw_last;
    cmd_e pc;
    cmd_q.delete(); len_q.delete(); wr_q.delete(); wl_q.delete();
    cap_cnt.delete(); cap_xor.delete(); cap_err.delete();
    mdl_n = '{0, 0}; mdl_x = '{8'h00, 8'h00};
    done_cnt = 0; lat = -1; stab_err = 0; timed_out = 1'b1;
    rbeat = 0; stall_w = 1'b0; stall_c = 1'b0; pw_data = '0; pw_last = 1'b0; pc = MAIN_CMD_IDLE;
    enable[sel] = 1'b1;
    for (int cyc = 1; cyc <= MAX_CYC; cyc++) begin
      @(posedge clk); #1;
      if (!hold) enable[sel] = 1'b0;
      if (lat < 0 && o_cmd_vld[sel]) lat = cyc;
      if (stall_w && (!o_wr_vld[sel] || o_wdata[sel] !== pw_data || o_wr_last[sel] !== pw_last)) stab_err++;
      if (stall_c && (!o_cmd_vld[sel] || o_cmd[sel] !== pc)) stab_err++;
      if (o_done[sel]) begin
        cap_cnt.push_back(o_rcnt[sel]);
        cap_xor.push_back(o_rxor[sel]);
        cap_err.push_back(o_err[sel]);
        done_cnt++;
        rbeat = 0;
      end
      if (done_cnt == n_done) begin
        timed_out = 1'b0;
        break;
      end
      cmd_ready = 1'($urandom_range(0, 1));
      case (wr_mode)
        0:       wr_ready = 1'b1;
        1:       wr_ready = ~wr_ready;
        default: wr_ready = 1'($urandom_range(0, 1));
      endcase
      rd_vld  = o_rd_ready[sel] && ($urandom_range(0, 3) != 0);
      rd_last = 1'b0;
      rd_data = 8'($urandom);
      if (rd_vld) begin
        if (rd_src.size() > 0) rd_data = rd_src.pop_front();
        rd_last = (rbeat + 1 == last_at);
        rbeat++;
        if (done_cnt < 2) begin
          mdl_n[done_cnt]++;
          mdl_x[done_cnt] ^= rd_data;
        end
      end
      if (o_cmd_vld[sel] && cmd_ready) begin
        cmd_q.push_back(o_cmd[sel]);
        len_q.push_back(o_blen[sel]);
      end
      if (o_wr_vld[sel] && wr_ready) begin
        wr_q.push_back(o_wdata[sel]);
        wl_q.push_back(o_wr_last[sel]);
      end
      stall_w = o_wr_vld[sel] && !wr_ready;
      pw_data = o_wdata[sel];
      pw_last = o_wr_last[sel];
      stall_c = o_cmd_vld[sel] && !cmd_ready;
      pc      = o_cmd[sel];
    end
    enable[sel] = 1'b0;
    cmd_ready = 1'b0; wr_ready = 1'b0; rd_vld = 1'b0; rd_last = 1'b0;
    @(posedge clk); #1;
    post_done = o_done[sel];
    post_busy = o_busy[sel];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < N_DUT; g++) begin
      checks++;
      if ({o_busy[g], o_done[g], o_err[g], o_cmd_vld[g], o_wr_vld[g], o_rd_ready[g], o_wr_last[g], o_rcnt[g], o_rxor[g]} !== 23'h0) begin
        failures++;
        $display("FAIL reset_outputs dut=%0d got=%0h exp=0", g,
                 {o_busy[g], o_done[g], o_err[g], o_cmd_vld[g], o_wr_vld[g], o_rd_ready[g], o_wr_last[g], o_rcnt[g], o_rxor[g]});
      end
      checks++;
      if (o_addr[g] !== 7'h50 || o_cmd[g] !== MAIN_CMD_IDLE) begin
        failures++;
        $display("FAIL reset_addr_cmd dut=%0d got addr=%0h cmd=%0d exp addr=50 cmd=0", g, o_addr[g], o_cmd[g]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    wr_mode = 0; last_at = 1; rd_src = '{8'hA5};
    run_txn(D_RD1, 1'b0, 1);
    checks++;
    if (timed_out !== 1'b0) begin failures++; $display("FAIL rd1_timeout got=%0d exp=0", timed_out); end
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL rd1_latency got=%0d exp=2", lat); end
    checks++;
    if (cmd_q.size() !== 1 || (cmd_q.size() == 1 && (cmd_q[0] !== COMPLETE_RD || len_q[0] !== 8'd1))) begin
      failures++; $display("FAIL rd1_cmd got n=%0d exp n=1 COMPLETE_RD len 1", cmd_q.size());
    end
    checks++;
    if (o_rcnt[D_RD1] !== 8'd1 || o_rxor[D_RD1] !== 8'hA5) begin
      failures++; $display("FAIL rd1_cnt_xor got=%0h/%0h exp=1/a5", o_rcnt[D_RD1], o_rxor[D_RD1]);
    end
    checks++;
    if (post_done !== 1'b0 || post_busy !== 1'b0 || o_err[D_RD1] !== 1'b0) begin
      failures++; $display("FAIL rd1_end got done=%0d busy=%0d err=%0d exp 0 0 0", post_done, post_busy, o_err[D_RD1]);
    end
  endtask

  task automatic test_missing_last();
    wr_mode = 0; last_at = 0; rd_src = {};
    run_txn(D_RD1, 1'b0, 1);
    checks++;
    if (timed_out !== 1'b0 || o_rcnt[D_RD1] !== 8'd1 || o_rxor[D_RD1] !== mdl_x[0]) begin
      failures++; $display("FAIL nolast_cnt got to=%0d cnt=%0h xor=%0h exp to=0 cnt=1 xor=%0h", timed_out, o_rcnt[D_RD1], o_rxor[D_RD1], mdl_x[0]);
    end
    checks++;
    if (o_err[D_RD1] !== 1'b1) begin failures++; $display("FAIL nolast_err got=%0d exp=1", o_err[D_RD1]); end
  endtask

  task automatic test_write();
    for (int r = 0; r < 3; r++) begin
      wr_mode = (r == 0) ? 1 : 2;
      run_txn(D_WR, 1'b0, 1);
      checks++;
      if (timed_out !== 1'b0 || cmd_q.size() !== 1 || (cmd_q.size() == 1 && (cmd_q[0] !== COMPLETE_WR || len_q[0] !== 8'd4))) begin
        failures++; $display("FAIL wr_cmd run=%0d got to=%0d n=%0d exp COMPLETE_WR len 4", r, timed_out, cmd_q.size());
      end
      checks++;
      if (wr_q.size() !== 4) begin failures++; $display("FAIL wr_beats run=%0d got=%0d exp=4", r, wr_q.size()); end
      for (int k = 0; k < wr_q.size() && k < 4; k++) begin
        checks++;
        if (wr_q[k] !== 8'(8'h81 + k) || wl_q[k] !== (k == 3)) begin
          failures++; $display("FAIL wr_byte run=%0d k=%0d got=%0h last=%0d exp=%0h last=%0d", r, k, wr_q[k], wl_q[k], 8'(8'h81 + k), (k == 3));
        end
      end
      checks++;
      if (stab_err !== 0 || o_err[D_WR] !== 1'b0 || post_busy !== 1'b0) begin
        failures++; $display("FAIL wr_stable run=%0d got stab=%0d err=%0d busy=%0d exp 0 0 0", r, stab_err, o_err[D_WR], post_busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    wr_mode = 0; cmd_ready = 1'b1; wr_ready = 1'b1;
    enable[D_WR] = 1'b1;
    @(posedge clk); #1;
    enable[D_WR] = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (o_wr_vld[D_WR] && o_wdata[D_WR] == 8'h82) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (found !== 1'b1) begin failures++; $display("FAIL rstmid_reach got=%0d exp=1", found); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (o_wr_vld[D_WR] !== 1'b0 || o_busy[D_WR] !== 1'b0 || o_cmd_vld[D_WR] !== 1'b0 || o_wr_last[D_WR] !== 1'b0) begin
      failures++; $display("FAIL rstmid_outputs got wr_vld=%0d busy=%0d exp 0 0", o_wr_vld[D_WR], o_busy[D_WR]);
    end
    rst_n = 1'b1; cmd_ready = 1'b0; wr_ready = 1'b0;
    @(posedge clk); #1;
    run_txn(D_WR, 1'b0, 1);
    checks++;
    if (timed_out !== 1'b0 || wr_q.size() !== 4 || (wr_q.size() == 4 && (wr_q[0] !== 8'h81 || wr_q[3] !== 8'h84))) begin
      failures++; $display("FAIL rstmid_restart got n=%0d exp 4 beats from 81", wr_q.size());
    end
  endtask

  task automatic test_wr_rd();
    wr_mode = 2; last_at = 3; rd_src = '{8'h01, 8'h02, 8'h04};
    run_txn(D_WRRD, 1'b0, 1);
    checks++;
    if (timed_out !== 1'b0 || cmd_q.size() !== 2 ||
        (cmd_q.size() == 2 && (cmd_q[0] !== WR_WNO_STOP || len_q[0] !== 8'd1 || cmd_q[1] !== COMPLETE_RD || len_q[1] !== 8'd3))) begin
      failures++; $display("FAIL wrrd_cmds got to=%0d n=%0d exp WR_WNO_STOP/1 then COMPLETE_RD/3", timed_out, cmd_q.size());
    end
    checks++;
    if (wr_q.size() !== 1 || (wr_q.size() == 1 && (wr_q[0] !== 8'h81 || wl_q[0] !== 1'b1))) begin
      failures++; $display("FAIL wrrd_ptr got n=%0d exp one beat 81 with last", wr_q.size());
    end
    checks++;
    if (o_rcnt[D_WRRD] !== 8'd3 || o_rxor[D_WRRD] !== 8'h07 || o_err[D_WRRD] !== 1'b0) begin
      failures++; $display("FAIL wrrd_read got cnt=%0h xor=%0h err=%0d exp 3 07 0", o_rcnt[D_WRRD], o_rxor[D_WRRD], o_err[D_WRRD]);
    end
  endtask

  task automatic test_random_read();
    for (int r = 0; r < 3; r++) begin
      wr_mode = 0; last_at = 4; rd_src = {};
      run_txn(D_RD4, 1'b0, 1);
      checks++;
      if (timed_out !== 1'b0 || o_rcnt[D_RD4] !== 8'd4 || mdl_n[0] !== 4 || o_rxor[D_RD4] !== mdl_x[0]) begin
        failures++; $display("FAIL rnd_read run=%0d got cnt=%0h xor=%0h exp cnt=4 xor=%0h", r, o_rcnt[D_RD4], o_rxor[D_RD4], mdl_x[0]);
      end
      checks++;
      if (o_err[D_RD4] !== 1'b0 || stab_err !== 0) begin
        failures++; $display("FAIL rnd_read_err run=%0d got err=%0d stab=%0d exp 0 0", r, o_err[D_RD4], stab_err);
      end
    end
  endtask

  task automatic test_early_last();
    wr_mode = 0; last_at = 2; rd_src = {};
    run_txn(D_RD4, 1'b0, 1);
    checks++;
    if (timed_out !== 1'b0 || o_rcnt[D_RD4] !== 8'd2 || o_rxor[D_RD4] !== mdl_x[0]) begin
      failures++; $display("FAIL early_cnt got cnt=%0h xor=%0h exp cnt=2 xor=%0h", o_rcnt[D_RD4], o_rxor[D_RD4], mdl_x[0]);
    end
    checks++;
    if (cap_err.size() !== 1 || (cap_err.size() == 1 && cap_err[0] !== 1'b1)) begin
      failures++; $display("FAIL early_err got n=%0d exp err=1 at done", cap_err.size());
    end
    last_at = 4;
    run_txn(D_RD4, 1'b0, 1);
    checks++;
    if (o_rcnt[D_RD4] !== 8'd4 || o_err[D_RD4] !== 1'b1) begin
      failures++; $display("FAIL err_sticky got cnt=%0h err=%0d exp cnt=4 err=1", o_rcnt[D_RD4], o_err[D_RD4]);
    end
  endtask

  task automatic test_back_to_back();
    wr_mode = 0; last_at = 2; rd_src = {};
    run_txn(D_RD2, 1'b1, 2);
    checks++;
    if (timed_out !== 1'b0 || done_cnt !== 2 || cmd_q.size() !== 2) begin
      failures++; $display("FAIL b2b_count got done=%0d cmds=%0d exp 2 2", done_cnt, cmd_q.size());
    end
    for (int t = 0; t < cap_cnt.size() && t < 2; t++) begin
      checks++;
      if (cap_cnt[t] !== 8'd2 || cap_xor[t] !== mdl_x[t] || cap_err[t] !== 1'b0) begin
        failures++; $display("FAIL b2b_txn t=%0d got cnt=%0h xor=%0h err=%0d exp cnt=2 xor=%0h err=0", t, cap_cnt[t], cap_xor[t], cap_err[t], mdl_x[t]);
      end
    end
    checks++;
    if (post_busy !== 1'b0 || post_done !== 1'b0) begin
      failures++; $display("FAIL b2b_end got busy=%0d done=%0d exp 0 0", post_busy, post_done);
    end
  endtask

  initial begin
    enable = '0; rst_n = 1'b0;
    cmd_ready = 1'b0; wr_ready = 1'b0; rd_vld = 1'b0; rd_last = 1'b0; rd_data = '0;
    wr_mode = 0; last_at = 0;
    test_reset();
    test_single_read();
    test_missing_last();
    test_write();
    test_reset_mid();
    test_wr_rd();
    test_random_read();
    test_early_last();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
